// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the mini MIPS core.
// It holds the program counter, the instruction memory and the next-PC logic.
// The run-control FSM (IDLE/RUN/HALT) and the saturating retired-instruction
// counter are also kept here. imem is filled through the load port while IDLE.
module instr_fetch_unit #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               LoadEn,
  input  logic [PC_W-1:0]    LoadAddr,
  input  logic [INSTR_W-1:0] LoadData,
  input  logic               Start,
  input  logic               Branch,
  input  logic               BranchSrc,
  input  logic               Zero,
  output logic [INSTR_W-1:0] Instruction,
  output logic [PC_W-1:0]    PC,
  output logic               InstrValid,
  output logic               Halted,
  output logic [CNT_W-1:0]   RetiredCount
);

  localparam int unsigned Depth = 2 ** PC_W;
  localparam logic [3:0] OpHalt = 4'b1110;
  localparam logic [3:0] OpJump = 4'b1100;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StRun     = 2'b01,
    StHalt    = 2'b10,
    StIllegal = 2'b11
  } state_e;

  logic [INSTR_W-1:0] imem [Depth];

  state_e             state_q;
  logic [PC_W-1:0]    pc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               halted_q;

  logic [INSTR_W-1:0] raw_instr;
  logic [3:0]         opcode;
  logic               is_halt;
  logic               is_jump;
  logic               br_taken;
  logic               running;
  logic [PC_W-1:0]    pc_seq;
  logic [PC_W-1:0]    br_off;
  logic [PC_W-1:0]    pc_branch;
  logic [PC_W-1:0]    jump_target;
  logic [PC_W-1:0]    pc_next;

  // Asynchronous imem read and instruction decode.
  assign raw_instr   = imem[pc_q];
  assign opcode      = raw_instr[INSTR_W-1 -: 4];
  assign is_halt     = (opcode == OpHalt);
  assign is_jump     = (opcode == OpJump);
  // beq takes the branch on Zero=1, bne on Zero=0.
  assign br_taken    = Branch & (Zero ^ BranchSrc);
  assign running     = (state_q == StRun);

  // PC arithmetic wraps naturally at PC_W bits.
  assign pc_seq      = pc_q + PC_W'(1);
  assign br_off      = {{(PC_W-6){raw_instr[5]}}, raw_instr[5:0]};
  assign pc_branch   = pc_seq + br_off;
  assign jump_target = raw_instr[PC_W-1:0];

  // Next-PC select: jump beats taken branch beats sequential (halt handled by the FSM).
  always_comb begin
    pc_next = pc_seq;
    if (is_jump) begin
      pc_next = jump_target;
    end else if (br_taken) begin
      pc_next = pc_branch;
    end
  end

  // Run-control FSM with PC, retired counter and Halted flag as registered state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (Start) begin
            state_q <= StRun;
            pc_q    <= '0;
            cnt_q   <= '0;
          end
        end
        StRun: begin
          if (is_halt) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end else begin
            pc_q <= pc_next;
            if (cnt_q != '1) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        StHalt: begin
          if (Start) begin
            state_q  <= StRun;
            halted_q <= 1'b0;
            pc_q     <= '0;
            cnt_q    <= '0;
          end
        end
        default: begin
          state_q  <= StIdle;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  // imem load port, only open while IDLE; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && LoadEn && (state_q == StIdle)) begin
      imem[LoadAddr] <= LoadData;
    end
  end

  assign InstrValid   = running & ~is_halt;
  assign Instruction  = InstrValid ? raw_instr : '0;
  assign PC           = pc_q;
  assign Halted       = halted_q;
  assign RetiredCount = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model. A second instance with a 4-bit counter covers saturation.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [15:0] load_data;
  logic        start;
  logic        branch;
  logic        branch_src;
  logic        zero;

  logic [15:0] instr_a;
  logic [7:0]  pc_a;
  logic        valid_a;
  logic        halted_a;
  logic [15:0] rc_a;

  logic [15:0] instr_b;
  logic [7:0]  pc_b;
  logic        valid_b;
  logic        halted_b;
  logic [3:0]  rc_b;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model state: 0 = idle, 1 = run, 2 = halt.
  logic [15:0] mem [256];
  int          m_state = 0;
  int          m_pc    = 0;
  int          m_cnt   = 0;
  bit          chk_en  = 0;

  instr_fetch_unit #(.PC_W(8), .INSTR_W(16), .CNT_W(16)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .LoadEn       (load_en),
    .LoadAddr     (load_addr),
    .LoadData     (load_data),
    .Start        (start),
    .Branch       (branch),
    .BranchSrc    (branch_src),
    .Zero         (zero),
    .Instruction  (instr_a),
    .PC           (pc_a),
    .InstrValid   (valid_a),
    .Halted       (halted_a),
    .RetiredCount (rc_a)
  );

  instr_fetch_unit #(.PC_W(8), .INSTR_W(16), .CNT_W(4)) u_sat (
    .clk          (clk),
    .reset        (reset),
    .LoadEn       (load_en),
    .LoadAddr     (load_addr),
    .LoadData     (load_data),
    .Start        (start),
    .Branch       (branch),
    .BranchSrc    (branch_src),
    .Zero         (zero),
    .Instruction  (instr_b),
    .PC           (pc_b),
    .InstrValid   (valid_b),
    .Halted       (halted_b),
    .RetiredCount (rc_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int c, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  // Random word with occasional halts and jumps.
  function automatic logic [15:0] rnd_word();
    logic [15:0] w;
    int r;
    w = 16'($urandom);
    r = $urandom_range(0, 15);
    if (r == 0) w[15:12] = 4'hE;
    else if (r == 1) w[15:12] = 4'hC;
    else if (w[15:12] == 4'hE || w[15:12] == 4'hC) w[15:12] = 4'h0;
    return w;
  endfunction

  // Reference model: one architectural step per clock edge.
  always @(posedge clk) begin
    logic [15:0] w;
    int imm;
    if (reset) begin
      m_state = 0;
      m_pc    = 0;
      m_cnt   = 0;
      chk_en  = 1;
    end else begin
      case (m_state)
        0: begin
          if (load_en) mem[load_addr] = load_data;
          if (start) begin
            m_state = 1;
            m_pc    = 0;
            m_cnt   = 0;
          end
        end
        1: begin
          w = mem[m_pc];
          if (w[15:12] == 4'hE) begin
            m_state = 2;
          end else begin
            m_cnt++;
            if (w[15:12] == 4'hC) begin
              m_pc = int'(w[7:0]);
            end else if (branch && (zero != branch_src)) begin
              imm  = w[5] ? int'(w[5:0]) - 64 : int'(w[5:0]);
              m_pc = (m_pc + 1 + imm) & 255;
            end else begin
              m_pc = (m_pc + 1) & 255;
            end
          end
        end
        default: begin
          if (start) begin
            m_state = 1;
            m_pc    = 0;
            m_cnt   = 0;
          end
        end
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [15:0] w;
    bit v;
    if (chk_en) begin
      w = mem[m_pc];
      v = (m_state == 1) && (w[15:12] != 4'hE);
      chk("pc", pc_a, m_pc);
      chk("valid", valid_a, v);
      chk("instr", instr_a, v ? w : 16'h0);
      chk("halted", halted_a, m_state == 2);
      chk("retired", rc_a, sat(m_cnt, 16));
      chk("sat_retired", rc_b, sat(m_cnt, 4));
      chk("sat_pc", pc_b, m_pc);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    cyc();
    load_en   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    load_en    = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    start      = 1'b1;
    branch     = 1'b0;
    branch_src = 1'b0;
    zero       = 1'b0;

    // T1: reset held two cycles with Start toggling.
    cyc();
    start = 1'b0;
    cyc();
    reset = 1'b0;
    chk("t1_pc", pc_a, 0);
    chk("t1_halted", halted_a, 0);
    chk("t1_valid", valid_a, 0);
    chk("t1_retired", rc_a, 0);
    cyc();
    chk("t1_idle_instr", instr_a, 0);

    for (int a = 0; a < 256; a++) load(8'(a), rnd_word());

    // T2: three R-type words then HALT.
    load(8'd0, 16'h0123);
    load(8'd1, 16'h1456);
    load(8'd2, 16'h2789);
    load(8'd3, 16'hE000);
    pulse_start();
    chk("t2_pc0", pc_a, 0);
    chk("t2_instr0", instr_a, 16'h0123);
    cyc();
    chk("t2_pc1", pc_a, 1);
    cyc();
    chk("t2_pc2", pc_a, 2);
    cyc();
    chk("t2_pc3", pc_a, 3);
    chk("t2_halt_valid", valid_a, 0);
    chk("t2_halt_instr", instr_a, 0);
    cyc();
    chk("t2_halted", halted_a, 1);
    chk("t2_retired", rc_a, 3);
    cyc();
    chk("t2_pc_hold", pc_a, 3);

    // T3: beq taken / not taken at PC=4.
    do_reset();
    load(8'd0, 16'hC004);
    load(8'd3, 16'h1000);
    load(8'd4, 16'h503E);
    load(8'd5, 16'hE000);
    pulse_start();
    cyc();
    chk("t3_jump4", pc_a, 4);
    branch = 1'b1; branch_src = 1'b0; zero = 1'b1;
    cyc();
    chk("t3_beq_taken", pc_a, 3);
    branch = 1'b0;
    cyc();
    branch = 1'b1; zero = 1'b0;
    cyc();
    chk("t3_beq_not_taken", pc_a, 5);
    branch = 1'b0;
    cyc();
    chk("t3_halted", halted_a, 1);
    chk("t3_retired", rc_a, 4);

    // T4: bne, jumps and wrap-around.
    do_reset();
    load(8'd0, 16'hC00A);
    load(8'd10, 16'h6005);
    load(8'd16, 16'hC020);
    load(8'h20, 16'hC0FF);
    load(8'hFF, 16'hC020);
    pulse_start();
    cyc();
    chk("t4_pc10", pc_a, 10);
    branch = 1'b1; branch_src = 1'b1; zero = 1'b0;
    cyc();
    chk("t4_bne_taken", pc_a, 16);
    branch = 1'b0; branch_src = 1'b0;
    cyc();
    chk("t4_jump20", pc_a, 8'h20);
    cyc();
    chk("t4_jumpff", pc_a, 8'hFF);
    cyc();
    chk("t4_jump_from_ff", pc_a, 8'h20);
    do_reset();
    chk("t4_reset_pc", pc_a, 0);
    load(8'd0, 16'hC0FF);
    load(8'hFF, 16'h1111);
    pulse_start();
    cyc();
    chk("t4_at_ff", pc_a, 8'hFF);
    cyc();
    chk("t4_wrap", pc_a, 0);

    // T5: load and start ignored mid-run, reset mid-run.
    do_reset();
    for (int i = 0; i < 8; i++) load(8'(i), 16'h2000 | 16'(i));
    load(8'd8, 16'hE000);
    pulse_start();
    load_en = 1'b1; load_addr = 8'd2; load_data = 16'hDEAD; start = 1'b1;
    cyc();
    load_en = 1'b0; start = 1'b0;
    chk("t5_start_ignored", pc_a, 1);
    cyc();
    chk("t5_instr2", instr_a, 16'h2002);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t5_reset_pc", pc_a, 0);
    chk("t5_reset_valid", valid_a, 0);
    chk("t5_reset_retired", rc_a, 0);
    pulse_start();
    cyc();
    cyc();
    chk("t5_imem_guard", instr_a, 16'h2002);

    // T6: counter saturation on the 4-bit instance, cleared by restart.
    do_reset();
    for (int i = 0; i < 18; i++) load(8'(i), 16'h3000 | 16'(i));
    load(8'd18, 16'h502E);
    load(8'd19, 16'hE000);
    pulse_start();
    zero = 1'b1; branch_src = 1'b0;
    for (int k = 0; k < 40; k++) begin
      branch = (m_pc == 18);
      cyc();
    end
    branch = 1'b0; zero = 1'b0;
    for (int k = 0; k < 40 && m_state != 2; k++) cyc();
    chk("t6_halted", halted_b, 1);
    chk("t6_sat", rc_b, 4'hF);
    chk("t6_wide_not_sat", rc_a > 16'd15, 1);
    pulse_start();
    chk("t6_restart_sat", rc_b, 0);
    chk("t6_restart_wide", rc_a, 0);
    chk("t6_restart_pc", pc_b, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int a = 0; a < 256; a++) load(8'(a), rnd_word());
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 299) == 0);
      start      = ($urandom_range(0, 19) == 0);
      load_en    = ($urandom_range(0, 3) == 0);
      load_addr  = 8'($urandom);
      load_data  = rnd_word();
      branch     = 1'($urandom);
      branch_src = 1'($urandom);
      zero       = 1'($urandom);
      cyc();
    end
    reset = 1'b0; start = 1'b0; load_en = 1'b0; branch = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
